// File: rtl/pipelined_cpu.sv
// Five-stage RV32I-subset pipeline (IF/ID/EX/MEM/WB) with internal memories,
// forwarding into EX, a one-cycle load-use stall and beq resolved in ID.

package pipelined_cpu_pkg;
  typedef enum logic [2:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluXor, AluSll, AluMul, AluSra
  } alu_op_e;
endpackage

module ProgramCounter (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic [31:0] pc_d_i,
  output logic [31:0] pc_o
);
  logic [31:0] pc_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni)   pc_q <= '0;
    else if (en_i) pc_q <= pc_d_i;
  end
  assign pc_o = pc_q;
endmodule

module PipeReg #(parameter int W = 32) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         hold_i,
  input  logic         clear_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o
);
  logic [W-1:0] data_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) data_q <= '0;
    else if (!hold_i)       data_q <= data_i;
  end
  assign data_o = data_q;
endmodule

module InstructionMemory (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [7:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [7:0]  raddr_i,
  output logic [31:0] instr_o
);
  logic [31:0] memory [0:255];
  // The write port exists for loaders; this processor never writes its own code.
  always_ff @(posedge clk_i) begin
    if (we_i) memory[waddr_i] <= wdata_i;
  end
  assign instr_o = memory[raddr_i];
endmodule

module DataMemory (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [4:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o
);
  logic [7:0] memory [0:31];
  logic [4:0] addr1, addr2, addr3;
  assign addr1 = addr_i + 5'd1;
  assign addr2 = addr_i + 5'd2;
  assign addr3 = addr_i + 5'd3;
  assign rdata_o = {memory[addr3], memory[addr2], memory[addr1], memory[addr_i]};
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      memory[addr_i] <= wdata_i[7:0];
      memory[addr1]  <= wdata_i[15:8];
      memory[addr2]  <= wdata_i[23:16];
      memory[addr3]  <= wdata_i[31:24];
    end
  end
endmodule

module RegisterFile (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  output logic [31:0] rs1Data_o,
  output logic [31:0] rs2Data_o
);
  logic [31:0] register [0:31];
  always_ff @(posedge clk_i) begin
    if (we_i && rd_i != 5'd0) register[rd_i] <= wdata_i;
  end
  // Write-through so an instruction in ID sees the value retiring in WB this cycle.
  always_comb begin
    rs1Data_o = register[rs1_i];
    rs2Data_o = register[rs2_i];
    if (we_i && rd_i != 5'd0 && rd_i == rs1_i) rs1Data_o = wdata_i;
    if (we_i && rd_i != 5'd0 && rd_i == rs2_i) rs2Data_o = wdata_i;
    if (rs1_i == 5'd0) rs1Data_o = '0;
    if (rs2_i == 5'd0) rs2Data_o = '0;
  end
endmodule

module CpuControl
  import pipelined_cpu_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic       regWrite_o,
  output logic       memRead_o,
  output logic       memWrite_o,
  output logic       aluSrc_o,
  output logic       Branch_o,
  output alu_op_e    aluOp_o
);
  always_comb begin
    regWrite_o = 1'b0;
    memRead_o  = 1'b0;
    memWrite_o = 1'b0;
    aluSrc_o   = 1'b0;
    Branch_o   = 1'b0;
    aluOp_o    = AluAdd;
    case (opcode_i)
      7'b0110011: begin
        regWrite_o = 1'b1;
        case ({funct7_i, funct3_i})
          {7'h00, 3'b000}: aluOp_o = AluAdd;
          {7'h20, 3'b000}: aluOp_o = AluSub;
          {7'h01, 3'b000}: aluOp_o = AluMul;
          {7'h00, 3'b001}: aluOp_o = AluSll;
          {7'h00, 3'b100}: aluOp_o = AluXor;
          {7'h00, 3'b110}: aluOp_o = AluOr;
          {7'h00, 3'b111}: aluOp_o = AluAnd;
          default:         regWrite_o = 1'b0;
        endcase
      end
      7'b0010011: begin
        aluSrc_o = 1'b1;
        if (funct3_i == 3'b000) regWrite_o = 1'b1;
        else if (funct3_i == 3'b101 && funct7_i == 7'h20) begin
          regWrite_o = 1'b1;
          aluOp_o    = AluSra;
        end
      end
      7'b0000011: if (funct3_i == 3'b010) begin
        regWrite_o = 1'b1;
        memRead_o  = 1'b1;
        aluSrc_o   = 1'b1;
      end
      7'b0100011: if (funct3_i == 3'b010) begin
        memWrite_o = 1'b1;
        aluSrc_o   = 1'b1;
      end
      7'b1100011: if (funct3_i == 3'b000) Branch_o = 1'b1;
      default: ;
    endcase
  end
endmodule

module HazardUnit (
  input  logic       exMemRead_i,
  input  logic [4:0] exRd_i,
  input  logic [4:0] idRs1_i,
  input  logic [4:0] idRs2_i,
  input  logic       idBranch_i,
  input  logic       regsEqual_i,
  output logic       Stall_o,
  output logic       Flush_o
);
  assign Stall_o = exMemRead_i && (exRd_i != 5'd0) && (exRd_i == idRs1_i || exRd_i == idRs2_i);
  assign Flush_o = !Stall_o && idBranch_i && regsEqual_i;
endmodule

module pipelined_cpu
  import pipelined_cpu_pkg::*;
(
  input logic clk_i,
  input logic start_i
);
  logic [31:0] pc, nextPc, fetchInstr, branchTarget, branchOffset;
  logic        stall, flush;
  logic [63:0] ifidQ;
  logic [31:0] idPc, idInstr, idImm, rs1Data, rs2Data;
  logic [4:0]  idRs1, idRs2, idRd;
  logic        idRegWrite, idMemRead, idMemWrite, idAluSrc, idBranch;
  alu_op_e     idAluOp;
  logic [117:0] idexQ;
  logic        exRegWrite, exMemRead, exMemWrite, exAluSrc;
  logic [2:0]  exAluOpBits;
  alu_op_e     exAluOp;
  logic [31:0] exRs1Data, exRs2Data, exImm, fwdA, fwdB, aluB, aluResult;
  logic [4:0]  exRs1, exRs2, exRd;
  logic [71:0] exmemQ;
  logic        memRegWrite, memMemRead, memMemWrite;
  logic [31:0] memAluResult, memStoreData, memReadData;
  logic [4:0]  memRd;
  logic [70:0] memwbQ;
  logic        wbRegWrite, wbMemRead;
  logic [31:0] wbAluResult, wbReadData, wbData;
  logic [4:0]  wbRd;

  assign nextPc = flush ? branchTarget : pc + 32'd4;
  ProgramCounter PC (.clk_i(clk_i), .rst_ni(start_i), .en_i(!stall), .pc_d_i(nextPc), .pc_o(pc));
  InstructionMemory Instruction_Memory (.clk_i(clk_i), .we_i(1'b0), .waddr_i(8'd0), .wdata_i(32'd0),
                                        .raddr_i(pc[9:2]), .instr_o(fetchInstr));
  PipeReg #(.W(64)) IFIDReg (.clk_i(clk_i), .rst_ni(start_i), .hold_i(stall), .clear_i(flush),
                             .data_i({pc, fetchInstr}), .data_o(ifidQ));

  assign {idPc, idInstr} = ifidQ;
  assign idRs1 = idInstr[19:15];
  assign idRs2 = idInstr[24:20];
  assign idRd  = idInstr[11:7];
  CpuControl Control (.opcode_i(idInstr[6:0]), .funct3_i(idInstr[14:12]), .funct7_i(idInstr[31:25]),
                      .regWrite_o(idRegWrite), .memRead_o(idMemRead), .memWrite_o(idMemWrite),
                      .aluSrc_o(idAluSrc), .Branch_o(idBranch), .aluOp_o(idAluOp));
  RegisterFile Registers (.clk_i(clk_i), .we_i(wbRegWrite && start_i), .rd_i(wbRd), .wdata_i(wbData),
                          .rs1_i(idRs1), .rs2_i(idRs2), .rs1Data_o(rs1Data), .rs2Data_o(rs2Data));
  always_comb begin
    idImm = {{20{idInstr[31]}}, idInstr[31:20]};
    if (idInstr[6:0] == 7'b0100011) idImm = {{20{idInstr[31]}}, idInstr[31:25], idInstr[11:7]};
  end
  assign branchOffset = {{19{idInstr[31]}}, idInstr[31], idInstr[7], idInstr[30:25], idInstr[11:8], 1'b0};
  assign branchTarget = idPc + branchOffset;
  HazardUnit HazardDetection (.exMemRead_i(exMemRead), .exRd_i(exRd), .idRs1_i(idRs1), .idRs2_i(idRs2),
                              .idBranch_i(idBranch), .regsEqual_i(rs1Data == rs2Data),
                              .Stall_o(stall), .Flush_o(flush));
  PipeReg #(.W(118)) IDEXReg (.clk_i(clk_i), .rst_ni(start_i), .hold_i(1'b0), .clear_i(stall),
                              .data_i({idRegWrite, idMemRead, idMemWrite, idAluSrc, idAluOp,
                                       rs1Data, rs2Data, idImm, idRs1, idRs2, idRd}),
                              .data_o(idexQ));

  assign {exRegWrite, exMemRead, exMemWrite, exAluSrc, exAluOpBits,
          exRs1Data, exRs2Data, exImm, exRs1, exRs2, exRd} = idexQ;
  assign exAluOp = alu_op_e'(exAluOpBits);
  // The younger result in EX/MEM shadows the older one in MEM/WB.
  assign fwdA = (memRegWrite && memRd != 5'd0 && memRd == exRs1) ? memAluResult :
                (wbRegWrite && wbRd != 5'd0 && wbRd == exRs1) ? wbData : exRs1Data;
  assign fwdB = (memRegWrite && memRd != 5'd0 && memRd == exRs2) ? memAluResult :
                (wbRegWrite && wbRd != 5'd0 && wbRd == exRs2) ? wbData : exRs2Data;
  assign aluB = exAluSrc ? exImm : fwdB;
  always_comb begin
    aluResult = '0;
    case (exAluOp)
      AluAdd:  aluResult = fwdA + aluB;
      AluSub:  aluResult = fwdA - aluB;
      AluAnd:  aluResult = fwdA & aluB;
      AluOr:   aluResult = fwdA | aluB;
      AluXor:  aluResult = fwdA ^ aluB;
      AluSll:  aluResult = fwdA << aluB[4:0];
      AluMul:  aluResult = fwdA * aluB;
      AluSra:  aluResult = $signed(fwdA) >>> aluB[4:0];
      default: aluResult = '0;
    endcase
  end
  PipeReg #(.W(72)) EXMEMReg (.clk_i(clk_i), .rst_ni(start_i), .hold_i(1'b0), .clear_i(1'b0),
                              .data_i({exRegWrite, exMemRead, exMemWrite, aluResult, fwdB, exRd}),
                              .data_o(exmemQ));

  assign {memRegWrite, memMemRead, memMemWrite, memAluResult, memStoreData, memRd} = exmemQ;
  DataMemory Data_Memory (.clk_i(clk_i), .we_i(memMemWrite && start_i), .addr_i(memAluResult[4:0]),
                          .wdata_i(memStoreData), .rdata_o(memReadData));
  PipeReg #(.W(71)) MEMWBReg (.clk_i(clk_i), .rst_ni(start_i), .hold_i(1'b0), .clear_i(1'b0),
                              .data_i({memRegWrite, memMemRead, memAluResult, memReadData, memRd}),
                              .data_o(memwbQ));

  assign {wbRegWrite, wbMemRead, wbAluResult, wbReadData, wbRd} = memwbQ;
  assign wbData = wbMemRead ? wbReadData : wbAluResult;
endmodule

// File: tb/tb_pipelined_cpu.sv
// Directed programs for pipelined_cpu; expected write-backs and stores are queued
// up front and a negedge monitor retires them in order against the DUT.

module tb_pipelined_cpu;
  logic clk_i = 1'b0;
  logic start_i = 1'b0;
  always #5 clk_i = ~clk_i;

  pipelined_cpu dut (.clk_i(clk_i), .start_i(start_i));

  int assertCount = 0;
  int failCount   = 0;
  int stallCount  = 0;
  int flushCount  = 0;
  logic [36:0] regQ [$];
  logic [36:0] memQ [$];
  logic [36:0] expected;
  logic [31:0] prog [$];
  logic [31:0] regInit [32];
  logic [7:0]  memInit [32];

  function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] encS(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] encB(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] want);
    assertCount++;
    if (actual !== want) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, want);
    end
  endtask

  task automatic pushReg(input logic [4:0] rd, input logic [31:0] value);
    regQ.push_back({rd, value});
  endtask

  task automatic clearSetup();
    prog.delete();
    regQ.delete();
    memQ.delete();
    for (int i = 0; i < 32; i++) begin
      regInit[i] = 32'h0;
      memInit[i] = 8'h0;
    end
  endtask

  // Hold reset for two edges, preload the memories and registers in between, then run.
  task automatic applyStimulus(input int cycles);
    start_i = 1'b0;
    @(posedge clk_i); #1;
    checkOutput("pc held at 0 in reset (edge 1)", dut.PC.pc_o, 32'h0);
    for (int i = 0; i < 256; i++)
      dut.Instruction_Memory.memory[i] = (i < prog.size()) ? prog[i] : 32'h0;
    for (int i = 0; i < 32; i++) begin
      dut.Registers.register[i] = regInit[i];
      dut.Data_Memory.memory[i] = memInit[i];
    end
    stallCount = 0;
    flushCount = 0;
    @(posedge clk_i); #1;
    checkOutput("pc held at 0 in reset (edge 2)", dut.PC.pc_o, 32'h0);
    start_i = 1'b1;
    repeat (cycles) @(posedge clk_i);
    #1;
  endtask

  task automatic checkDrained(input string name);
    checkOutput({name, " writebacks all seen"}, regQ.size(), 32'd0);
    checkOutput({name, " stores all seen"}, memQ.size(), 32'd0);
  endtask

  always @(negedge clk_i) begin
    if (start_i) begin
      if (dut.HazardDetection.Stall_o) stallCount++;
      if (dut.HazardDetection.Flush_o) flushCount++;
      if (dut.wbRegWrite && dut.wbRd != 5'd0) begin
        if (regQ.size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL unexpected writeback: x%0d = 0x%08h, expected none", dut.wbRd, dut.wbData);
        end else begin
          expected = regQ.pop_front();
          checkOutput("writeback rd", {27'b0, dut.wbRd}, {27'b0, expected[36:32]});
          checkOutput("writeback data", dut.wbData, expected[31:0]);
        end
      end
      if (dut.memMemWrite) begin
        if (memQ.size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL unexpected store: addr 0x%02h, expected none", dut.memAluResult[4:0]);
        end else begin
          expected = memQ.pop_front();
          checkOutput("store addr", {27'b0, dut.memAluResult[4:0]}, {27'b0, expected[36:32]});
          checkOutput("store data", dut.memStoreData, expected[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] reset / empty program");
    clearSetup();
    regInit[5] = 32'h0000_1234;
    memInit[0] = 8'hA5;
    applyStimulus(0);
    @(posedge clk_i); #1; checkOutput("pc after 1st run edge", dut.PC.pc_o, 32'd4);
    @(posedge clk_i); #1; checkOutput("pc after 2nd run edge", dut.PC.pc_o, 32'd8);
    @(posedge clk_i); #1; checkOutput("pc after 3rd run edge", dut.PC.pc_o, 32'd12);
    repeat (5) @(posedge clk_i); #1;
    checkOutput("x5 untouched", dut.Registers.register[5], 32'h0000_1234);
    checkOutput("mem[0] untouched", {24'b0, dut.Data_Memory.memory[0]}, 32'h0000_00A5);
    checkDrained("reset");

    $display("[TB] forwarding");
    clearSetup();
    prog.push_back(encI(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011));
    prog.push_back(encI(12'd3, 5'd1, 3'b000, 5'd2, 7'b0010011));
    prog.push_back(encR(7'h00, 5'd2, 5'd1, 3'b000, 5'd3));
    prog.push_back(encR(7'h20, 5'd1, 5'd3, 3'b000, 5'd4));
    pushReg(5'd1, 32'd5); pushReg(5'd2, 32'd8); pushReg(5'd3, 32'd13); pushReg(5'd4, 32'd8);
    applyStimulus(14);
    checkOutput("forwarding x4", dut.Registers.register[4], 32'd8);
    checkOutput("forwarding stall count", stallCount, 32'd0);
    checkDrained("forwarding");

    $display("[TB] load-use");
    clearSetup();
    memInit[0] = 8'd5;
    prog.push_back(encI(12'd0, 5'd0, 3'b010, 5'd5, 7'b0000011));
    prog.push_back(encR(7'h00, 5'd5, 5'd5, 3'b000, 5'd6));
    prog.push_back(encS(12'd4, 5'd6, 5'd0));
    pushReg(5'd5, 32'd5); pushReg(5'd6, 32'd10);
    memQ.push_back({5'd4, 32'd10});
    applyStimulus(14);
    checkOutput("load-use word 0x04", {dut.Data_Memory.memory[7], dut.Data_Memory.memory[6],
                                       dut.Data_Memory.memory[5], dut.Data_Memory.memory[4]}, 32'd10);
    checkOutput("load-use stall count", stallCount, 32'd1);
    checkDrained("load-use");

    // beq compares raw register values, so two NOPs let x2 reach write-back first.
    for (int variant = 0; variant < 2; variant++) begin
      $display("[TB] branch variant %0d", variant);
      clearSetup();
      prog.push_back(encI(12'd1, 5'd0, 3'b000, 5'd1, 7'b0010011));
      prog.push_back(encI((variant == 0) ? 12'd1 : 12'd2, 5'd0, 3'b000, 5'd2, 7'b0010011));
      prog.push_back(32'h0);
      prog.push_back(32'h0);
      prog.push_back(encB(13'd8, 5'd2, 5'd1));
      prog.push_back(encI(12'd99, 5'd0, 3'b000, 5'd7, 7'b0010011));
      prog.push_back(encI(12'd7, 5'd0, 3'b000, 5'd8, 7'b0010011));
      pushReg(5'd1, 32'd1);
      pushReg(5'd2, (variant == 0) ? 32'd1 : 32'd2);
      if (variant == 1) pushReg(5'd7, 32'd99);
      pushReg(5'd8, 32'd7);
      applyStimulus(16);
      checkOutput("branch x7", dut.Registers.register[7], (variant == 0) ? 32'd0 : 32'd99);
      checkOutput("branch x8", dut.Registers.register[8], 32'd7);
      checkOutput("branch flush count", flushCount, (variant == 0) ? 32'd1 : 32'd0);
      checkDrained("branch");
    end

    $display("[TB] ALU ops");
    clearSetup();
    regInit[1] = 32'hFFFF_FFF0;
    regInit[2] = 32'd3;
    prog.push_back(encR(7'h01, 5'd2, 5'd1, 3'b000, 5'd3));
    prog.push_back(encR(7'h00, 5'd2, 5'd1, 3'b001, 5'd4));
    prog.push_back(encI({7'h20, 5'd2}, 5'd1, 3'b101, 5'd5, 7'b0010011));
    prog.push_back(encR(7'h00, 5'd2, 5'd1, 3'b100, 5'd6));
    prog.push_back(encR(7'h00, 5'd2, 5'd1, 3'b111, 5'd7));
    prog.push_back(encR(7'h00, 5'd2, 5'd1, 3'b110, 5'd8));
    prog.push_back(encR(7'h20, 5'd2, 5'd1, 3'b000, 5'd9));
    prog.push_back(encR(7'h20, 5'd2, 5'd1, 3'b001, 5'd10));
    prog.push_back(32'hFFFF_FFFF);
    pushReg(5'd3, 32'hFFFF_FFD0);
    pushReg(5'd4, 32'hFFFF_FF80);
    pushReg(5'd5, 32'hFFFF_FFFC);
    pushReg(5'd6, 32'hFFFF_FFF3);
    pushReg(5'd7, 32'h0000_0000);
    pushReg(5'd8, 32'hFFFF_FFF3);
    pushReg(5'd9, 32'hFFFF_FFED);
    applyStimulus(18);
    checkOutput("invalid encoding leaves x10", dut.Registers.register[10], 32'h0);
    checkDrained("alu");

    $display("[TB] x0 and wrap-around");
    clearSetup();
    prog.push_back(encI(12'd5, 5'd0, 3'b000, 5'd0, 7'b0010011));
    prog.push_back(encI(12'hFFF, 5'd0, 3'b000, 5'd1, 7'b0010011));
    prog.push_back(encR(7'h00, 5'd1, 5'd1, 3'b000, 5'd2));
    pushReg(5'd1, 32'hFFFF_FFFF);
    pushReg(5'd2, 32'hFFFF_FFFE);
    applyStimulus(12);
    checkOutput("x0 stays zero", dut.Registers.register[0], 32'h0);
    checkOutput("x2 wrap", dut.Registers.register[2], 32'hFFFF_FFFE);
    checkDrained("x0");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
